// File: rtl/enc_pkg.sv
// Shared types and constants for the instruction encoder/loader: kind codes,
// RV32I major opcodes, loader FSM states and an immediate range helper.
package enc_pkg;

  typedef enum logic [2:0] {
    KIND_LW    = 3'd0,
    KIND_SW    = 3'd1,
    KIND_BEQ   = 3'd2,
    KIND_JAL   = 3'd3,
    KIND_RTYPE = 3'd4,
    KIND_ITYPE = 3'd5,
    KIND_RSV6  = 3'd6,
    KIND_RSV7  = 3'd7
  } kind_e;

  // Major opcodes, identical to the values the control decoder matches on.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // True when the 21-bit immediate is representable as a 'bits'-wide signed value.
  function automatic logic fits_signed(input logic [20:0] imm, input int bits);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 21; b++) begin
      if (b >= bits - 1 && imm[b] != imm[20]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_enc.sv
// Combinational RV32I encoder for the six supported instruction kinds.
// Optional immediate range checking is enabled with ENC_RANGE_CHECK_EN.
module instr_enc
  import enc_pkg::*;
(
  input  kind_e       kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [20:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        range_err
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind)
      KIND_LW:    word = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
      KIND_SW:    word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
      KIND_BEQ:   word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_BRANCH};
      KIND_JAL:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      KIND_RTYPE: word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OPC_OP};
      KIND_ITYPE: word = {imm[11:0], rs1, funct3, rd, OPC_OPIMM};
      default:    illegal = 1'b1;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // Branch and jump targets must be halfword aligned; others must fit their field.
  always_comb begin
    range_err = 1'b0;
    case (kind)
      KIND_LW, KIND_SW, KIND_ITYPE: range_err = !fits_signed(imm, 12);
      KIND_BEQ:                     range_err = !fits_signed(imm, 13) || imm[0];
      KIND_JAL:                     range_err = imm[0];
      default:                      range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts instruction fields, encodes them to RV32I words and streams the words
// into instruction memory from BASE_ADDR. Optional macro: ENC_RANGE_CHECK_EN.
module instr_encoder_loader
  import enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_kind,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7b5,
  input  logic [20:0] in_imm,
  input  logic        in_last,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  input  logic        imem_ready,
  output logic        done,
  output logic        err
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

  state_e      state_reg, state_next;
  logic [31:0] enc_word_reg;
  logic        enc_pending_reg;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0] count_reg;
  logic [AW:0] occupancy;
  logic [31:0] addr_reg;
  logic        err_reg;

  logic [31:0] enc_word;
  logic        enc_illegal, enc_range_err;
  logic        transfer, push, pop, drained;

  instr_enc u_enc (
    .kind      (kind_e'(in_kind)),
    .rd        (in_rd),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .funct3    (in_funct3),
    .funct7b5  (in_funct7b5),
    .imm       (in_imm),
    .word      (enc_word),
    .illegal   (enc_illegal),
    .range_err (enc_range_err)
  );

  // The word sitting in the encode register is counted as occupied so that
  // accepting fields can never overrun the buffer one cycle later.
  assign occupancy  = count_reg + {{AW{1'b0}}, enc_pending_reg};
  assign in_ready   = !reset && (state_reg != ST_DONE) && (occupancy < DEPTH_C);
  assign transfer   = in_valid && in_ready;
  assign push       = enc_pending_reg;
  assign imem_we    = (count_reg != '0);
  assign pop        = imem_we && imem_ready;
  assign imem_wdata = imem_we ? mem[rd_ptr_reg] : '0;
  assign imem_addr  = addr_reg;
  assign done       = (state_reg == ST_DONE);
  assign err        = err_reg;

  assign drained = !enc_pending_reg && !transfer &&
                   ((count_reg == '0) || ((count_reg == ONE_C) && pop));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (transfer) state_next = in_last ? ST_DRAIN : ST_LOAD;
      ST_LOAD:  if (transfer && in_last) state_next = ST_DRAIN;
      ST_DRAIN: if (drained) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      enc_word_reg    <= '0;
      enc_pending_reg <= 1'b0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      addr_reg        <= BASE_ADDR;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      enc_pending_reg <= transfer && !enc_illegal && !enc_range_err;
      if (transfer) enc_word_reg <= enc_word;
      if (transfer && (enc_illegal || enc_range_err)) err_reg <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + ONE_C;
        2'b01:   count_reg <= count_reg - ONE_C;
        default: count_reg <= count_reg;
      endcase
      // Entering DONE rewinds the write address for the next program.
      if (state_next == ST_DONE) addr_reg <= BASE_ADDR;
      else if (pop) addr_reg <= addr_reg + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= enc_word_reg;
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized self-checking bench for instr_encoder_loader against a field-level
// RV32I reference model and an expected-write queue.
module tb_instr_encoder_loader;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_kind = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_funct7b5 = 1'b0;
  logic [20:0] in_imm = '0;
  logic        in_last = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr, imem_wdata;
  logic        imem_ready = 1'b1;
  logic        done, err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_addr = BASE;
  int  done_cnt = 0;
  int  exp_done = 0;
  bit  exp_err = 0;
  bit  saw_stall = 0;
  int  n_acc = 0;
  bit  rand_rdy = 0;

  instr_encoder_loader #(.BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_ready(imem_ready), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference encoding built directly from the RV32I field layout.
  function automatic logic [31:0] model_enc(int kind, int rd, int rs1, int rs2,
                                            int f3, int f7, int imm);
    logic [31:0] i, d, s1, s2, f;
    i = imm; d = rd; s1 = rs1; s2 = rs2; f = f3;
    case (kind)
      0: return ((i & 32'hfff) << 20) | (s1 << 15) | (32'd2 << 12) | (d << 7) | 32'h03;
      1: return (((i >> 5) & 32'h7f) << 25) | (s2 << 20) | (s1 << 15) | (32'd2 << 12)
                | ((i & 32'h1f) << 7) | 32'h23;
      2: return (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3f) << 25) | (s2 << 20)
                | (s1 << 15) | (((i >> 1) & 32'hf) << 8) | (((i >> 11) & 32'h1) << 7) | 32'h63;
      3: return (((i >> 20) & 32'h1) << 31) | (((i >> 1) & 32'h3ff) << 21)
                | (((i >> 11) & 32'h1) << 20) | (((i >> 12) & 32'hff) << 12) | (d << 7) | 32'h6f;
      4: return ((f7 != 0 ? 32'h1 : 32'h0) << 30) | (s2 << 20) | (s1 << 15) | (f << 12)
                | (d << 7) | 32'h33;
      default: return ((i & 32'hfff) << 20) | (s1 << 15) | (f << 12) | (d << 7) | 32'h13;
    endcase
  endfunction

  function automatic bit model_legal(int kind, int imm);
    if (kind > 5) return 0;
`ifdef ENC_RANGE_CHECK_EN
    if ((kind == 0 || kind == 1 || kind == 5) && (imm < -2048 || imm > 2047)) return 0;
    if (kind == 2 && (imm < -4096 || imm > 4095 || (imm % 2) != 0)) return 0;
    if (kind == 3 && (imm % 2) != 0) return 0;
`endif
    return 1;
  endfunction

  task automatic send(input int kind, input int rd, input int rs1, input int rs2,
                      input int f3, input int f7, input int imm, input bit last,
                      input bit use_exp, input logic [31:0] exp_word);
    int waited = 0;
    @(negedge clk);
    in_kind = 3'(kind); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_funct3 = 3'(f3); in_funct7b5 = (f7 != 0); in_imm = 21'(imm); in_last = last;
    in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 300) begin
      @(negedge clk); #1; waited++;
    end
    if (waited > 0) saw_stall = 1;
    if (!in_ready) begin
      check("in_ready_timeout", {31'b0, in_ready}, 32'h1);
      in_valid = 1'b0;
      return;
    end
    if (model_legal(kind, imm))
      exp_q.push_back(use_exp ? exp_word : model_enc(kind, rd, rs1, rs2, f3, f7, imm));
    else
      exp_err = 1;
    $display("send kind=%0d rd=%0d rs1=%0d rs2=%0d imm=%0d last=%0d", kind, rd, rs1, rs2, imm, last);
    n_acc++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    exp_done++;
    while (done_cnt < exp_done && n < 400) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    check("done_cnt", done_cnt, exp_done);
    check("queue_drained", exp_q.size(), 0);
    check("err_flag", {31'b0, err}, {31'b0, exp_err});
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("rst_we", {31'b0, imem_we}, 0);
    check("rst_addr", imem_addr, BASE);
    check("rst_ready", {31'b0, in_ready}, 0);
    check("rst_err", {31'b0, err}, 0);
    exp_q.delete();
    model_addr = BASE;
    exp_err = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Write monitor: every completed write must match the head of the model queue.
  always begin
    @(negedge clk); #1;
    if (!reset) begin
      if (imem_we && imem_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {31'b0, imem_we}, 0);
        end else begin
          logic [31:0] w;
          w = exp_q.pop_front();
          check("wr_data", imem_wdata, w);
          check("wr_addr", imem_addr, model_addr);
          $display("write addr=0x%08h data=0x%08h", imem_addr, imem_wdata);
          model_addr = model_addr + 32'd4;
        end
      end
      if (done) begin
        done_cnt++;
        check("done_addr", imem_addr, BASE);
        model_addr = BASE;
      end
    end
  end

  always begin
    @(negedge clk);
    if (rand_rdy) imem_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset: outputs must clear before any clock edge.
    #3 reset = 1'b1;
    #1;
    check("init_ready", {31'b0, in_ready}, 0);
    check("init_we", {31'b0, imem_we}, 0);
    check("init_wdata", imem_wdata, 0);
    check("init_addr", imem_addr, BASE);
    check("init_done", {31'b0, done}, 0);
    check("init_err", {31'b0, err}, 0);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    #1 check("ready_after_rst", {31'b0, in_ready}, 1);

    send(0, 5, 2, 0, 0, 0, 8, 1, 1, 32'h00812283);
    wait_done();

    send(4, 3, 1, 2, 0, 0, 0, 0, 1, 32'h002081B3);
    send(4, 3, 1, 2, 0, 1, 0, 1, 1, 32'h402081B3);
    wait_done();

    send(2, 0, 1, 2, 0, 0, 8, 1, 1, 32'h00208463);
    wait_done();
    check("addr_back_base", imem_addr, BASE);

    // Back-pressure: six words while the memory stalls for ten cycles.
    imem_ready = 1'b0; saw_stall = 0; n_acc = 0;
    fork
      begin
        for (int k = 0; k < 6; k++)
          send(k % 6, k + 1, k + 2, k + 3, k % 8, k % 2, 4 * k - 8, k == 5, 0, 32'h0);
      end
      begin
        repeat (10) @(negedge clk);
        check("accepted_while_stalled", n_acc, 4);
        imem_ready = 1'b1;
      end
    join
    wait_done();
    check("stall_seen", {31'b0, saw_stall}, 1);

    // Illegal kind as the final instruction: flagged, dropped, program still ends.
    send(7, 1, 1, 1, 0, 0, 0, 1, 0, 32'h0);
    wait_done();
    pulse_reset();

`ifdef ENC_RANGE_CHECK_EN
    send(0, 1, 1, 0, 0, 0, 4096, 1, 0, 32'h0);
    wait_done();
    pulse_reset();
`endif

    // Reset with three words buffered discards them.
    imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(5, k + 1, 2, 0, 1, 0, k, 0, 0, 32'h0);
    @(posedge clk); #1;
    check("buffered_we", {31'b0, imem_we}, 1);
    reset = 1'b1;
    #1;
    check("midrst_we", {31'b0, imem_we}, 0);
    check("midrst_addr", imem_addr, BASE);
    check("midrst_ready", {31'b0, in_ready}, 0);
    exp_q.delete(); model_addr = BASE; exp_err = 0;
    @(negedge clk);
    reset = 1'b0;
    imem_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_we", {31'b0, imem_we}, 0);

    // Randomized programs with random memory back-pressure.
    rand_rdy = 1;
    for (int p = 0; p < 10; p++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        int kind, imm;
        kind = ($urandom_range(0, 15) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
        if ($urandom_range(0, 1) == 1) imm = $urandom_range(0, 4095) - 2048;
        else imm = $urandom_range(0, 2097151) - 1048576;
        send(kind, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 7), $urandom_range(0, 1), imm, k == len - 1, 0, 32'h0);
      end
      wait_done();
    end
    rand_rdy = 0;
    imem_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("final_done_cnt", done_cnt, exp_done);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
